// File: rtl/baccarat_pkg.sv
// -----------------------------------------------------------------------------
// baccarat_pkg
// Shared types and constants for the baccarat round sequencer.
//   state_t : round sequencing states
//   load_t  : bundle of the six card-register load strobes
//   NATURAL_MIN / PLAYER_DRAW_MAX / DEALER_STAND / FACE_MIN : rule thresholds
// -----------------------------------------------------------------------------
package baccarat_pkg;

    typedef enum logic [3:0] {
        S_START,
        S_DEAL_P1,
        S_DEAL_D1,
        S_DEAL_P2,
        S_DEAL_D2,
        S_CHECK,
        S_DEAL_P3,
        S_CHECK_D3,
        S_DEAL_D3,
        S_RESULT
    } state_t;

    typedef struct packed {
        logic pcard1;
        logic pcard2;
        logic pcard3;
        logic dcard1;
        logic dcard2;
        logic dcard3;
    } load_t;

    localparam logic [3:0] NATURAL_MIN     = 4'd8;
    localparam logic [3:0] PLAYER_DRAW_MAX = 4'd5;
    localparam logic [3:0] DEALER_STAND    = 4'd7;
    localparam logic [3:0] FACE_MIN        = 4'd10;

    // Baccarat point value of a card rank: tens and face cards count as zero.
    function automatic logic [3:0] card_value(input logic [3:0] rank);
        return (rank >= FACE_MIN) ? 4'd0 : rank;
    endfunction

endpackage

// File: rtl/baccarat_sequencer_dealer_draw_rule.sv
// -----------------------------------------------------------------------------
// dealer_draw_rule
// Purely combinational third-card rule for the dealer, applied after the
// player has drawn a third card.
//   dscore [3:0] : dealer two-card score, 0..9
//   pcard3 [3:0] : player third card rank, 1..13
//   draw         : 1 when the dealer must take a third card
// -----------------------------------------------------------------------------
module dealer_draw_rule
    import baccarat_pkg::*;
(
    input  logic [3:0] dscore,
    input  logic [3:0] pcard3,
    output logic       draw
);

    logic [3:0] value;

    always_comb begin
        value = card_value(pcard3);
        draw  = 1'b0;
        if (dscore <= 4'd2) begin
            draw = 1'b1;
        end else if (dscore == DEALER_STAND) begin
            draw = 1'b0;
        end else begin
            case (dscore)
                4'd3:    draw = (value != 4'd8);
                4'd4:    draw = (value >= 4'd2) && (value <= 4'd7);
                4'd5:    draw = (value >= 4'd4) && (value <= 4'd7);
                4'd6:    draw = (value >= 4'd6) && (value <= 4'd7);
                default: draw = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/baccarat_sequencer.sv
// -----------------------------------------------------------------------------
// baccarat_sequencer
// Steps one baccarat round: deals the four opening cards, resolves naturals
// and the third-card rules, then holds the result until reset.
//   slow_clock          : one deal step per rising edge
//   reset               : asynchronous, active-high, returns to S_START
//   pscore / dscore     : hand scores (0..9) from the datapath scorers
//   pcard3              : loaded player third card rank
//   load_pcard1..3      : player card register load strobes
//   load_dcard1..3      : dealer card register load strobes
//   player_win / dealer_win : winner flags, both high on a tie
//   done                : round complete
// -----------------------------------------------------------------------------
module baccarat_sequencer
    import baccarat_pkg::*;
(
    input  logic       slow_clock,
    input  logic       reset,
    input  logic [3:0] pscore,
    input  logic [3:0] dscore,
    input  logic [3:0] pcard3,
    output logic       load_pcard1,
    output logic       load_pcard2,
    output logic       load_pcard3,
    output logic       load_dcard1,
    output logic       load_dcard2,
    output logic       load_dcard3,
    output logic       player_win,
    output logic       dealer_win,
    output logic       done
);

    state_t state_q, state_d;
    load_t  load_q,  load_d;
    logic   done_q,  done_d;
    logic   dealer_draw;

    dealer_draw_rule u_dealer_draw_rule (
        .dscore (dscore),
        .pcard3 (pcard3),
        .draw   (dealer_draw)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_START:    state_d = S_DEAL_P1;
            S_DEAL_P1:  state_d = S_DEAL_D1;
            S_DEAL_D1:  state_d = S_DEAL_P2;
            S_DEAL_P2:  state_d = S_DEAL_D2;
            S_DEAL_D2:  state_d = S_CHECK;
            S_CHECK: begin
                if ((pscore >= NATURAL_MIN) || (dscore >= NATURAL_MIN))
                    state_d = S_RESULT;
                else if (pscore <= PLAYER_DRAW_MAX)
                    state_d = S_DEAL_P3;
                // Standing player: the dealer draws on the same 0..5 band.
                else if (dscore <= PLAYER_DRAW_MAX)
                    state_d = S_DEAL_D3;
                else
                    state_d = S_RESULT;
            end
            S_DEAL_P3:  state_d = S_CHECK_D3;
            S_CHECK_D3: state_d = dealer_draw ? S_DEAL_D3 : S_RESULT;
            S_DEAL_D3:  state_d = S_RESULT;
            S_RESULT:   state_d = S_RESULT;
            default:    state_d = S_START;
        endcase
    end

    // NOTE: the strobes and done are decoded from the *next* state and
    // registered, so they are glitch-free and line up exactly with state_q.
    always_comb begin
        load_d = '0;
        case (state_d)
            S_DEAL_P1: load_d.pcard1 = 1'b1;
            S_DEAL_D1: load_d.dcard1 = 1'b1;
            S_DEAL_P2: load_d.pcard2 = 1'b1;
            S_DEAL_D2: load_d.dcard2 = 1'b1;
            S_DEAL_P3: load_d.pcard3 = 1'b1;
            S_DEAL_D3: load_d.dcard3 = 1'b1;
            default:   load_d = '0;
        endcase
        done_d = (state_d == S_RESULT);
    end

    // NOTE: reset is asynchronous so a mid-round reset clears every output
    // immediately rather than at the next slow_clock edge.
    always_ff @(posedge slow_clock or posedge reset) begin
        if (reset) begin
            state_q <= S_START;
            load_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            load_q  <= load_d;
            done_q  <= done_d;
        end
    end

    assign load_pcard1 = load_q.pcard1;
    assign load_pcard2 = load_q.pcard2;
    assign load_pcard3 = load_q.pcard3;
    assign load_dcard1 = load_q.dcard1;
    assign load_dcard2 = load_q.dcard2;
    assign load_dcard3 = load_q.dcard3;
    assign done        = done_q;

    // Scores are stable in S_RESULT (no further loads), so the win flags can
    // be decoded directly from them; a tie raises both.
    assign player_win = (state_q == S_RESULT) && (pscore >= dscore);
    assign dealer_win = (state_q == S_RESULT) && (dscore >= pscore);

endmodule

// File: tb/tb_baccarat_sequencer.sv
module tb_baccarat_sequencer;

    logic       slow_clock = 1'b0;
    logic       reset      = 1'b0;
    logic [3:0] pscore, dscore, pcard3;
    logic       load_pcard1, load_pcard2, load_pcard3;
    logic       load_dcard1, load_dcard2, load_dcard3;
    logic       player_win, dealer_win, done;

    always #5 slow_clock = ~slow_clock;

    baccarat_sequencer dut (
        .slow_clock  (slow_clock),
        .reset       (reset),
        .pscore      (pscore),
        .dscore      (dscore),
        .pcard3      (pcard3),
        .load_pcard1 (load_pcard1),
        .load_pcard2 (load_pcard2),
        .load_pcard3 (load_pcard3),
        .load_dcard1 (load_dcard1),
        .load_dcard2 (load_dcard2),
        .load_dcard3 (load_dcard3),
        .player_win  (player_win),
        .dealer_win  (dealer_win),
        .done        (done)
    );

    // Deck order: player1, dealer1, player2, dealer2, player3, dealer3.
    logic [3:0] deck [6];
    logic [3:0] pc1, pc2, pc3, dc1, dc2, dc3;

    function automatic int val(input logic [3:0] r);
        return (r >= 4'd10) ? 0 : int'(r);
    endfunction

    // Datapath stand-in: card registers plus scorers.
    always @(posedge slow_clock or posedge reset) begin
        if (reset) begin
            pc1 <= 0; pc2 <= 0; pc3 <= 0; dc1 <= 0; dc2 <= 0; dc3 <= 0;
        end else begin
            if (load_pcard1) pc1 <= deck[0];
            if (load_dcard1) dc1 <= deck[1];
            if (load_pcard2) pc2 <= deck[2];
            if (load_dcard2) dc2 <= deck[3];
            if (load_pcard3) pc3 <= deck[4];
            if (load_dcard3) dc3 <= deck[5];
        end
    end

    always_comb begin
        pscore = 4'((val(pc1) + val(pc2) + val(pc3)) % 10);
        dscore = 4'((val(dc1) + val(dc2) + val(dc3)) % 10);
        pcard3 = pc3;
    end

    // Reference model: plays the round straight from the baccarat rules.
    typedef struct {
        int pw;
        int dw;
        int latency;
        int p3;
        int d3;
    } exp_t;

    exp_t exp_q[$];

    function automatic bit dealer_hits(input int d, input int v);
        int lo [7] = '{0, 0, 0, 0, 2, 4, 6};
        if (d <= 2) return 1'b1;
        if (d == 3) return v != 8;
        if (d <= 6) return (v >= lo[d]) && (v <= 7);
        return 1'b0;
    endfunction

    function automatic exp_t model();
        exp_t e;
        int p, d, v;
        p = (val(deck[0]) + val(deck[2])) % 10;
        d = (val(deck[1]) + val(deck[3])) % 10;
        e.p3 = 0;
        e.d3 = 0;
        if (p >= 8 || d >= 8) begin
            e.latency = 6;
        end else if (p <= 5) begin
            e.p3 = 1;
            v = val(deck[4]);
            p = (p + v) % 10;
            if (dealer_hits(d, v)) begin
                e.d3 = 1;
                d = (d + val(deck[5])) % 10;
                e.latency = 9;
            end else begin
                e.latency = 8;
            end
        end else if (d <= 5) begin
            e.d3 = 1;
            d = (d + val(deck[5])) % 10;
            e.latency = 7;
        end else begin
            e.latency = 6;
        end
        e.pw = (p >= d) ? 1 : 0;
        e.dw = (d >= p) ? 1 : 0;
        return e;
    endfunction

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Per-round counters, sampled on the clock edge that consumes each strobe.
    int edges = 0;
    int cnt_p3 = 0;
    int cnt_d3 = 0;

    always @(posedge slow_clock or posedge reset) begin
        if (reset) begin
            edges  <= 0;
            cnt_p3 <= 0;
            cnt_d3 <= 0;
        end else begin
            edges  <= edges + 1;
            cnt_p3 <= cnt_p3 + int'(load_pcard3);
            cnt_d3 <= cnt_d3 + int'(load_dcard3);
        end
    end

    int   rounds_started = 0;
    int   rounds_checked = 0;
    exp_t cur;

    // Monitor: samples on the falling edge, pops the scoreboard on done.
    always begin
        logic [5:0] loads;
        @(negedge slow_clock or posedge reset);
        loads = {load_pcard1, load_dcard1, load_pcard2, load_dcard2, load_pcard3, load_dcard3};
        if (reset) begin
            #1;
            check("reset_outputs",
                  int'({load_pcard1, load_dcard1, load_pcard2, load_dcard2, load_pcard3,
                        load_dcard3, player_win, dealer_win, done}), 0);
        end else begin
            if (edges >= 1 && edges <= 4)
                check("deal_strobe", int'(loads), 32'b100000 >> (edges - 1));
            if (done) begin
                check("no_load_in_result", int'(loads), 0);
                if (rounds_checked < rounds_started) begin
                    if (exp_q.size() > 0) begin
                        cur = exp_q.pop_front();
                        check("latency", edges, cur.latency);
                        check("pcard3_loads", cnt_p3, cur.p3);
                        check("dcard3_loads", cnt_d3, cur.d3);
                    end else begin
                        check("scoreboard_empty", 0, 1);
                    end
                    rounds_checked++;
                end
                check("player_win", int'(player_win), cur.pw);
                check("dealer_win", int'(dealer_win), cur.dw);
            end else begin
                check("win_before_done", int'({player_win, dealer_win}), 0);
                if (edges > 20 && rounds_checked < rounds_started) begin
                    check("round_timeout", edges, 20);
                    if (exp_q.size() > 0) void'(exp_q.pop_front());
                    rounds_checked++;
                end
            end
        end
    end

    task automatic play(input logic [3:0] c0, input logic [3:0] c1, input logic [3:0] c2,
                        input logic [3:0] c3, input logic [3:0] c4, input logic [3:0] c5,
                        input int hold);
        @(posedge slow_clock);
        #3 reset = 1'b1;
        deck[0] = c0; deck[1] = c1; deck[2] = c2;
        deck[3] = c3; deck[4] = c4; deck[5] = c5;
        exp_q.push_back(model());
        rounds_started++;
        @(posedge slow_clock);
        #3 reset = 1'b0;
        wait (rounds_checked == rounds_started);
        repeat (hold) @(posedge slow_clock);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        #2 reset = 1'b1;
        deck[0] = 4'd1; deck[1] = 4'd1; deck[2] = 4'd1;
        deck[3] = 4'd1; deck[4] = 4'd1; deck[5] = 4'd1;
        @(posedge slow_clock);
        #3 reset = 1'b0;
        // Abort a round while in S_DEAL_P2, then restart cleanly.
        repeat (3) @(posedge slow_clock);
        #3 reset = 1'b1;

        play(4'd3, 4'd1, 4'd5, 4'd2, 4'd4,  4'd4, 1);   // natural 8 vs 3
        play(4'd3, 4'd1, 4'd4, 4'd3, 4'd9,  4'd5, 1);   // player 7 stands, dealer 4 draws to 9
        play(4'd1, 4'd1, 4'd1, 4'd2, 4'd8,  4'd6, 1);   // player draws 8, dealer 3 stands
        play(4'd2, 4'd2, 4'd1, 4'd2, 4'd12, 4'd7, 1);   // face third card, dealer 4 stands
        play(4'd1, 4'd3, 4'd1, 4'd3, 4'd6,  4'd2, 1);   // third card 6, dealer 6 draws
        play(4'd3, 4'd2, 4'd3, 4'd4, 4'd1,  4'd1, 10);  // 6 vs 6 tie, held 10 edges

        for (int i = 0; i < 40; i++) begin
            play(4'($urandom_range(1, 13)), 4'($urandom_range(1, 13)),
                 4'($urandom_range(1, 13)), 4'($urandom_range(1, 13)),
                 4'($urandom_range(1, 13)), 4'($urandom_range(1, 13)),
                 int'($urandom_range(0, 3)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
